alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Upstream driver for the 32-bit MIPS ALU: accepts a decoded instruction (opcode, funct, imm16) plus two
//  register operands over valid/ready, derives the 4-bit ALU control code and operand B, and drives the ALU.
//  Captures ALUOut and zero, resolves beq/bne, returns the result over valid/ready.
//  Sits between the register-read stage and writeback/branch logic of the multicycle datapath.
// PARAMETERS
//  WIDTH   32  datapath width (operands, ALU result)
//  CTL_W   4   ALU control code width
// PORTS
//  clk            in   1      single clock, rising edge
//  reset          in   1      synchronous, active-high
//  in_valid       in   1      instruction/operands presented
//  in_ready       out  1      block can accept (IDLE only)
//  opcode         in   6      instr[31:26]
//  funct          in   6      instr[5:0], used when opcode==0
//  imm16          in   16     instr[15:0]
//  rs_val         in   WIDTH  operand A
//  rt_val         in   WIDTH  operand B (R-type, beq/bne)
//  alu_a          out  WIDTH  to ALU a (registered)
//  alu_b          out  WIDTH  to ALU b (registered)
//  alu_ctl        out  CTL_W  to ALU ALUctl (registered)
//  alu_out        in   WIDTH  from ALU ALUOut (combinational)
//  alu_zero       in   2      from ALU zero; only bit 0 meaningful
//  out_valid      out  1      result available
//  out_ready      in   1      consumer accepts result
//  result         out  WIDTH  captured ALU result
//  branch_taken   out  1      beq: zero; bne: ~zero; else 0
//  illegal        out  1      unsupported opcode/funct; result forced 0
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=1, out_valid=0, result=0, branch_taken=0, illegal=0, alu_a=alu_b=0, alu_ctl=4'b0000.
//  - FSM: IDLE -(in_valid)-> ISSUE -> CAPTURE -(out_ready)-> IDLE; CAPTURE holds while !out_ready.
//  - Accept cycle N: latch decoded ctl, alu_a=rs_val, alu_b=selected B; ISSUE in N+1 (ALU settles combinationally).
//  - End of ISSUE: register alu_out->result, alu_zero[0] into branch logic; out_valid=1 from N+2.
//  - Latency accept->out_valid = 2 cycles; max throughput 1 per 3 cycles; result/flags stable while out_valid&!out_ready.
//  - Decode (ctl): R-type funct 100000 add->0010, 100010 sub->0110, 100100 and->0000, 100101 or->0001,
//    101010 slt->0111; lw 100011 / sw 101011 / addi 001000 ->0010, B=sign-ext imm16; andi 001100 ->0000,
//    ori 001101 ->0001, B=zero-ext imm16; slti 001010 ->0111, B=sign-ext; beq 000100 / bne 000101 ->0110, B=rt_val.
//  - Illegal encoding: alu_ctl/alu_a/alu_b keep prior values (no new ALU op), FSM still passes ISSUE,
//    result=0, illegal=1, branch_taken=0; same latency as a legal op.
//  - Only the five legal codes are ever driven on alu_ctl (ALU holds ALUOut on other codes).
//  - slt/slti: signedness is the ALU's (unsigned a<b); block does not correct it.
//  - Arithmetic wraps mod 2^WIDTH; no overflow detection.
//  - in_valid while !in_ready: ignored, inputs not sampled. Inputs only sampled on in_valid&in_ready.
//  - reset asserted in any state: next cycle IDLE with reset values; in-flight op dropped, no out_valid.
// STRUCTURE
//  - Shared include alu_defs.vh: opcode/funct constants, ALU ctl codes (AND/OR/ADD/SUB/SLT), FSM state encodings.
//  - Sub-module alu_issue_decode: pure combinational {opcode,funct,imm16,rt_val} -> {ctl, b_sel_val, is_beq, is_bne, illegal}.
//  - Top: 3-state FSM, operand/ctl registers, result/flag capture registers.
// TESTING (bench instantiates real ALU)
//  - add: R-type funct 100000, rs=5, rt=7 -> out_valid at N+2, result=12, illegal=0, branch_taken=0.
//  - addi: opcode 001000, rs=10, imm16=16'hFFFF -> alu_b=32'hFFFFFFFF, result=9; ori imm16=16'h8000, rs=1 -> result=32'h00008001.
//  - beq/bne: rs=rt=3 -> beq taken=1, bne taken=0; rs=3, rt=4 -> beq 0, bne 1; ctl=0110 both.
//  - backpressure: out_ready=0 for 5 cycles after sub 9-4 -> result=5 held, in_ready=0, new in_valid ignored; release -> IDLE.
//  - illegal: opcode 000000 funct 001000 -> result=0, illegal=1, alu_ctl unchanged from prior op.
//  - reset during ISSUE of and 32'hF0F0/32'hFF00 -> next cycle IDLE, out_valid=0, all outputs reset values.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: MIPS opcode/funct encodings,
// ALU control codes, FSM state encoding and operand-B source selection.
package alu_issue_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] CTL_AND = 4'b0000;
   localparam logic [3:0] CTL_OR  = 4'b0001;
   localparam logic [3:0] CTL_ADD = 4'b0010;
   localparam logic [3:0] CTL_SUB = 4'b0110;
   localparam logic [3:0] CTL_SLT = 4'b0111;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      BSEL_RT   = 2'd0,
      BSEL_SEXT = 2'd1,
      BSEL_ZEXT = 2'd2
   } bsel_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of a MIPS instruction into ALU control code, operand B
// and branch/illegal flags. Unsupported encodings report illegal with ctl=AND.
module alu_issue_decode
   import alu_issue_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [5:0]       i_opcode,
   input  logic [5:0]       i_funct,
   input  logic [15:0]      i_imm16,
   input  logic [WIDTH-1:0] i_rt_val,
   output logic [3:0]       o_ctl,
   output logic [WIDTH-1:0] o_b_val,
   output logic             o_is_beq,
   output logic             o_is_bne,
   output logic             o_illegal
);

   bsel_t            w_bsel;
   logic [WIDTH-1:0] w_sext;
   logic [WIDTH-1:0] w_zext;

   assign w_sext = {{(WIDTH-16){i_imm16[15]}}, i_imm16};
   assign w_zext = {{(WIDTH-16){1'b0}}, i_imm16};

   always_comb begin
      o_ctl     = CTL_AND;
      w_bsel    = BSEL_RT;
      o_is_beq  = 1'b0;
      o_is_bne  = 1'b0;
      o_illegal = 1'b0;
      case (i_opcode)
         OP_RTYPE: begin
            case (i_funct)
               FN_ADD:  o_ctl = CTL_ADD;
               FN_SUB:  o_ctl = CTL_SUB;
               FN_AND:  o_ctl = CTL_AND;
               FN_OR:   o_ctl = CTL_OR;
               FN_SLT:  o_ctl = CTL_SLT;
               default: o_illegal = 1'b1;
            endcase
         end
         OP_LW, OP_SW, OP_ADDI: begin
            o_ctl  = CTL_ADD;
            w_bsel = BSEL_SEXT;
         end
         OP_ANDI: begin
            o_ctl  = CTL_AND;
            w_bsel = BSEL_ZEXT;
         end
         OP_ORI: begin
            o_ctl  = CTL_OR;
            w_bsel = BSEL_ZEXT;
         end
         OP_SLTI: begin
            o_ctl  = CTL_SLT;
            w_bsel = BSEL_SEXT;
         end
         OP_BEQ: begin
            o_ctl    = CTL_SUB;
            o_is_beq = 1'b1;
         end
         OP_BNE: begin
            o_ctl    = CTL_SUB;
            o_is_bne = 1'b1;
         end
         default: o_illegal = 1'b1;
      endcase
   end

   always_comb begin
      o_b_val = i_rt_val;
      case (w_bsel)
         BSEL_SEXT: o_b_val = w_sext;
         BSEL_ZEXT: o_b_val = w_zext;
         default:   o_b_val = i_rt_val;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded instruction at a time to an external combinational MIPS
// ALU, captures ALUOut/zero, resolves beq/bne and returns the result.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CTL_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic [15:0]      imm16,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [CTL_W-1:0] alu_ctl,
   input  logic [WIDTH-1:0] alu_out,
   input  logic [1:0]       alu_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             branch_taken,
   output logic             illegal,
   output logic [1:0]       o_dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // in_ready is high only in IDLE; out_valid stays high with result/flags
   // frozen until out_ready is seen.

   state_t           r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [CTL_W-1:0] r_alu_ctl;
   logic [WIDTH-1:0] r_result;
   logic             r_taken;
   logic             r_illegal;
   logic             r_pend_beq;
   logic             r_pend_bne;
   logic             r_pend_ill;

   logic [3:0]       w_dec_ctl;
   logic [WIDTH-1:0] w_dec_b;
   logic             w_dec_beq;
   logic             w_dec_bne;
   logic             w_dec_ill;
   logic             w_zero;
   logic             w_accept;
   logic             w_zero_unused;

   alu_issue_decode #(.WIDTH(WIDTH)) u_decode (
      .i_opcode  (opcode),
      .i_funct   (funct),
      .i_imm16   (imm16),
      .i_rt_val  (rt_val),
      .o_ctl     (w_dec_ctl),
      .o_b_val   (w_dec_b),
      .o_is_beq  (w_dec_beq),
      .o_is_bne  (w_dec_bne),
      .o_illegal (w_dec_ill)
   );

   // Only bit 0 of the ALU zero bus carries information.
   assign w_zero        = alu_zero[0];
   assign w_zero_unused = alu_zero[1];
   assign w_accept      = in_valid && r_in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_ctl   <= CTL_W'(CTL_AND);
         r_result    <= '0;
         r_taken     <= 1'b0;
         r_illegal   <= 1'b0;
         r_pend_beq  <= 1'b0;
         r_pend_bne  <= 1'b0;
         r_pend_ill  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_pend_beq <= w_dec_beq;
                  r_pend_bne <= w_dec_bne;
                  r_pend_ill <= w_dec_ill;
                  // An illegal op leaves the ALU inputs untouched.
                  if (!w_dec_ill) begin
                     r_alu_a   <= rs_val;
                     r_alu_b   <= w_dec_b;
                     r_alu_ctl <= CTL_W'(w_dec_ctl);
                  end
                  r_in_ready <= 1'b0;
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_result    <= r_pend_ill ? '0 : alu_out;
               r_taken     <= !r_pend_ill &&
                              ((r_pend_beq && w_zero) || (r_pend_bne && !w_zero));
               r_illegal   <= r_pend_ill;
               r_out_valid <= 1'b1;
               r_state     <= S_CAPTURE;
            end
            S_CAPTURE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready     = r_in_ready;
   assign out_valid    = r_out_valid;
   assign alu_a        = r_alu_a;
   assign alu_b        = r_alu_b;
   assign alu_ctl      = r_alu_ctl;
   assign result       = r_result;
   assign branch_taken = r_taken;
   assign illegal      = r_illegal;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl driving a behavioural MIPS ALU, with an
// expected-result queue filled at issue time and drained when out_valid rises.
module tb_alu_issue_ctrl;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic [15:0]      imm16;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [3:0]       alu_ctl;
   logic [WIDTH-1:0] alu_out;
   logic [1:0]       alu_zero;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             branch_taken;
   logic             illegal;
   logic [1:0]       dbg_state;

   int checks = 0;
   int errors = 0;
   logic [WIDTH+1:0] exp_q[$];

   alu_issue_ctrl #(.WIDTH(WIDTH), .CTL_W(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .opcode       (opcode),
      .funct        (funct),
      .imm16        (imm16),
      .rs_val       (rs_val),
      .rt_val       (rt_val),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_ctl      (alu_ctl),
      .alu_out      (alu_out),
      .alu_zero     (alu_zero),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .branch_taken (branch_taken),
      .illegal      (illegal),
      .o_dbg_state  (dbg_state)
   );

   // Clock / reset block
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500000");
      $fatal(1, "watchdog");
   end

   // Behavioural MIPS ALU: unsigned slt, zero on bit 0.
   always_comb begin
      case (alu_ctl)
         4'b0000: alu_out = alu_a & alu_b;
         4'b0001: alu_out = alu_a | alu_b;
         4'b0010: alu_out = alu_a + alu_b;
         4'b0110: alu_out = alu_a - alu_b;
         4'b0111: alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
         4'b1100: alu_out = ~(alu_a | alu_b);
         default: alu_out = '0;
      endcase
   end
   assign alu_zero = {1'b0, (alu_out == '0)};

   task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                        input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_result"}, result, 0);
      check({tag, "_taken"}, branch_taken, 0);
      check({tag, "_illegal"}, illegal, 0);
      check({tag, "_alu_a"}, alu_a, 0);
      check({tag, "_alu_b"}, alu_b, 0);
      check({tag, "_alu_ctl"}, alu_ctl, 0);
      check({tag, "_state"}, dbg_state, 0);
   endtask

   task automatic pop_and_compare(input string tag);
      logic [WIDTH+1:0] e;
      e = exp_q.pop_front();
      check({tag, "_result"}, result, e[WIDTH-1:0]);
      check({tag, "_taken"}, branch_taken, WIDTH'(e[WIDTH]));
      check({tag, "_illegal"}, illegal, WIDTH'(e[WIDTH+1]));
   endtask

   // Driver: one full transaction with out_ready held high.
   task automatic send(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic [15:0] imm, input logic [WIDTH-1:0] rs,
                       input logic [WIDTH-1:0] rt, input logic [3:0] exp_ctl,
                       input logic [WIDTH-1:0] exp_a, input logic [WIDTH-1:0] exp_b,
                       input logic [WIDTH-1:0] exp_res, input logic exp_taken,
                       input logic exp_ill);
      int cyc;
      @(negedge clk);
      check({tag, "_in_ready"}, in_ready, 1);
      opcode    = op;
      funct     = fn;
      imm16     = imm;
      rs_val    = rs;
      rt_val    = rt;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      exp_q.push_back({exp_ill, exp_taken, exp_res});
      @(negedge clk);
      in_valid = 1'b0;
      opcode   = 6'($urandom_range(0, 63));
      rs_val   = $urandom;
      rt_val   = $urandom;
      cyc      = 1;
      check({tag, "_busy"}, in_ready, 0);
      check({tag, "_alu_ctl"}, alu_ctl, exp_ctl);
      check({tag, "_alu_a"}, alu_a, exp_a);
      check({tag, "_alu_b"}, alu_b, exp_b);
      while (!out_valid && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_out_valid"}, out_valid, 1);
      check({tag, "_latency"}, cyc, 2);
      pop_and_compare(tag);
      @(negedge clk);
      check({tag, "_done_valid"}, out_valid, 0);
      check({tag, "_done_ready"}, in_ready, 1);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      opcode    = '0;
      funct     = '0;
      imm16     = '0;
      rs_val    = '0;
      rt_val    = '0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b0;

      send("add",   6'b000000, 6'b100000, 16'h0000, 32'd5, 32'd7,
           4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
      send("addi",  6'b001000, 6'b000000, 16'hFFFF, 32'd10, 32'd0,
           4'b0010, 32'd10, 32'hFFFFFFFF, 32'd9, 1'b0, 1'b0);
      send("ori",   6'b001101, 6'b000000, 16'h8000, 32'd1, 32'd0,
           4'b0001, 32'd1, 32'h00008000, 32'h00008001, 1'b0, 1'b0);
      send("andi",  6'b001100, 6'b000000, 16'h00FF, 32'hFFFF1234, 32'd0,
           4'b0000, 32'hFFFF1234, 32'h000000FF, 32'h00000034, 1'b0, 1'b0);
      send("lw",    6'b100011, 6'b000000, 16'hFFFC, 32'd100, 32'd0,
           4'b0010, 32'd100, 32'hFFFFFFFC, 32'd96, 1'b0, 1'b0);
      send("slti",  6'b001010, 6'b000000, 16'hFFFF, 32'd5, 32'd0,
           4'b0111, 32'd5, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
      send("or",    6'b000000, 6'b100101, 16'h0000, 32'hF0, 32'h0F,
           4'b0001, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0);
      send("slt",   6'b000000, 6'b101010, 16'h0000, 32'd7, 32'd3,
           4'b0111, 32'd7, 32'd3, 32'd0, 1'b0, 1'b0);
      send("beq_eq", 6'b000100, 6'b000000, 16'h0010, 32'd3, 32'd3,
           4'b0110, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0);
      send("bne_eq", 6'b000101, 6'b000000, 16'h0010, 32'd3, 32'd3,
           4'b0110, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);
      send("beq_ne", 6'b000100, 6'b000000, 16'h0010, 32'd3, 32'd4,
           4'b0110, 32'd3, 32'd4, 32'hFFFFFFFF, 1'b0, 1'b0);
      send("bne_ne", 6'b000101, 6'b000000, 16'h0010, 32'd3, 32'd4,
           4'b0110, 32'd3, 32'd4, 32'hFFFFFFFF, 1'b1, 1'b0);
      // Illegal funct: ALU inputs keep the bne values (3, 4, SUB).
      send("ill_fn", 6'b000000, 6'b001000, 16'h1234, 32'd77, 32'd88,
           4'b0110, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1);

      // Backpressure: sub 9-4 held for five cycles while new requests are offered.
      @(negedge clk);
      opcode    = 6'b000000;
      funct     = 6'b100010;
      rs_val    = 32'd9;
      rt_val    = 32'd4;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      exp_q.push_back({1'b0, 1'b0, 32'd5});
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      pop_and_compare("bp");
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         funct    = 6'b100000;
         rs_val   = $urandom;
         rt_val   = $urandom;
         @(negedge clk);
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_result", result, 32'd5);
         check("bp_hold_ready", in_ready, 0);
         check("bp_hold_alu_a", alu_a, 32'd9);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", out_valid, 0);
      check("bp_release_ready", in_ready, 1);
      check("bp_release_state", dbg_state, 0);

      // Reset during ISSUE of and F0F0/FF00 drops the operation.
      @(negedge clk);
      opcode   = 6'b000000;
      funct    = 6'b100100;
      rs_val   = 32'h0000F0F0;
      rt_val   = 32'h0000FF00;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("rst_issue_state", dbg_state, 1);
      check("rst_issue_alu_a", alu_a, 32'h0000F0F0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_values("rst_mid");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_no_valid", out_valid, 0);
      end

      // Illegal opcode straight after reset keeps the reset ALU inputs.
      send("ill_op", 6'b111111, 6'b100000, 16'hABCD, 32'd1, 32'd2,
           4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      send("sw",    6'b101011, 6'b000000, 16'h0008, 32'h00001000, 32'd0,
           4'b0010, 32'h00001000, 32'h00000008, 32'h00001008, 1'b0, 1'b0);

      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
